// File: rtl/mod_seq.sv
// mod_seq: unsigned A mod B by repeated subtraction, one subtract per cycle, quotient in iter_count
module mod_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] R,
    output logic             valid,
    output logic             busy,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] iter_count
);
    localparam logic [1:0] IDLE = 2'd0, SUB = 2'd1, DONE = 2'd2;
    logic [1:0] state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d, b_q, b_d, cnt_q, cnt_d;
    logic dbz_q, dbz_d;
    logic [WIDTH-1:0] diff;
    logic no_borrow;
    // R + ~B + 1: the carry out doubles as the unsigned R >= B compare
    assign {no_borrow, diff} = {1'b0, r_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
    always_comb begin
        state_d = state_q;
        r_d = r_q;
        b_d = b_q;
        cnt_d = cnt_q;
        dbz_d = dbz_q;
        if (state_q == IDLE) begin
            if (start) begin
                b_d = B;
                r_d = A;
                cnt_d = '0;
                dbz_d = 1'b0;
                state_d = SUB;
            end
        end else if (state_q == SUB) begin
            if (b_q == '0) begin
                dbz_d = 1'b1;
                state_d = DONE;
            end else if (!no_borrow) begin
                state_d = DONE;
            end else begin
                r_d = diff;
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q <= '0;
            b_q <= '0;
            cnt_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q <= r_d;
            b_q <= b_d;
            cnt_q <= cnt_d;
            dbz_q <= dbz_d;
        end
    end
    assign R = r_q;
    assign iter_count = cnt_q;
    assign div_by_zero = dbz_q;
    assign valid = (state_q == DONE);
    assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_mod_seq.sv
// tb_mod_seq: scoreboard bench for mod_seq; expectations queued at issue, checked when valid pulses
module tb_mod_seq;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [31:0] A = '0, B = '0;
    logic [31:0] R, iter_count;
    logic valid, busy, div_by_zero;
    int total = 0, bad = 0, cyc = 0;
    typedef struct {
        logic [31:0] r;
        logic [31:0] cnt;
        logic        dbz;
        int          at;
    } exp_t;
    exp_t sb[$];

    mod_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .R(R),
        .valid(valid), .busy(busy), .div_by_zero(div_by_zero), .iter_count(iter_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every valid pulse must match the oldest queued expectation, on the expected edge
    always @(negedge clk) begin
        if (valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("R", R, e.r);
                chk("iter_count", iter_count, e.cnt);
                chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
                chk("valid_cycle", cyc, e.at);
            end
        end
    end

    // lat = edges from the start-sampling edge to the edge that enters DONE
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                         input logic [31:0] c, input logic d, input int lat, input bit push);
        exp_t e;
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        e.r = r;
        e.cnt = c;
        e.dbz = d;
        e.at = cyc + 1 + lat;
        if (push) sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("timeout", 32'd1, 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                       input logic [31:0] c, input logic d, input int lat);
        issue(a, b, r, c, d, lat, 1'b1);
        wait_done();
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_R", R, 32'd0);
        chk("rst_iter", iter_count, 32'd0);
        chk("rst_flags", {29'd0, valid, busy, div_by_zero}, 32'd0);

        issue(32'd17, 32'd5, 32'd2, 32'd3, 1'b0, 4, 1'b1);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy) n++;
            @(negedge clk);
        end
        chk("busy_cycles", n, 32'd5);
        wait_done();
        repeat (3) @(negedge clk);
        chk("hold_R", R, 32'd2);
        chk("hold_iter", iter_count, 32'd3);
        chk("idle_flags", {30'd0, valid, busy}, 32'd0);

        run(32'd4, 32'd9, 32'd4, 32'd0, 1'b0, 1);
        run(32'd9, 32'd9, 32'd0, 32'd1, 1'b0, 2);
        run(32'd7, 32'd0, 32'd7, 32'd0, 1'b1, 1);
        run(32'd10, 32'd3, 32'd1, 32'd3, 1'b0, 4);
        run(32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1'b0, 2);
        run(32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1);

        issue(32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 15, 1'b1);
        @(negedge clk);
        A = 32'd5;
        B = 32'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        issue(32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_R", R, 32'd0);
        chk("abort_iter", iter_count, 32'd0);
        repeat (20) @(negedge clk);
        run(32'd10, 32'd3, 32'd1, 32'd3, 1'b0, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
